// File: rtl/cordic_arbiter.sv
// Two-channel round-robin front end for a shared CORDIC core: grants one
// requester, launches the core, waits for completion or watchdog abort.
module cordic_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int W       = 13
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         Req0,
    input  logic         Req1,
    input  logic [W-1:0] I0,
    input  logic [W-1:0] Q0,
    input  logic [W-1:0] I1,
    input  logic [W-1:0] Q1,
    output logic         Grant0,
    output logic         Grant1,
    output logic         Done0,
    output logic         Done1,
    output logic         Err0,
    output logic         Err1,
    output logic [W-1:0] Res_PM,
    output logic [W-1:0] Res_AM,
    output logic         Busy,
    output logic         Cordic_Enable,
    output logic [W-1:0] I,
    output logic [W-1:0] Q,
    input  logic         Cordic_Ready,
    input  logic [W-1:0] PM,
    input  logic [W-1:0] AM
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam bit          WATCHDOG_ON  = (TIMEOUT != 0);

    state_t         state_reg, state_next;
    logic           owner_reg, owner_next;
    logic           last_reg, last_next;
    logic           abort_reg, abort_next;
    logic [15:0]    count_reg, count_next;
    logic [W-1:0]   op_i_reg, op_i_next;
    logic [W-1:0]   op_q_reg, op_q_next;
    logic [W-1:0]   res_pm_reg, res_pm_next;
    logic [W-1:0]   res_am_reg, res_am_next;

    logic [1:0]     req_vec;
    logic [W-1:0]   chan_i [2];
    logic [W-1:0]   chan_q [2];
    logic           winner;
    logic           timeout_hit;

    logic [1:0]     grant_vec;
    logic [1:0]     done_vec;
    logic [1:0]     err_vec;

    assign req_vec   = {Req1, Req0};
    assign chan_i[0] = I0;
    assign chan_i[1] = I1;
    assign chan_q[0] = Q0;
    assign chan_q[1] = Q1;

    // On a tie the channel that was not granted last wins.
    always_comb begin
        winner = 1'b0;
        case (req_vec)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_reg;
            default: winner = 1'b0;
        endcase
    end

    assign timeout_hit = WATCHDOG_ON && (count_reg == TIMEOUT_LAST);

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        last_next   = last_reg;
        abort_next  = abort_reg;
        count_next  = count_reg;
        op_i_next   = op_i_reg;
        op_q_next   = op_q_reg;
        res_pm_next = res_pm_reg;
        res_am_next = res_am_reg;

        case (state_reg)
            ST_IDLE: begin
                if (|req_vec) begin
                    state_next = ST_ISSUE;
                    owner_next = winner;
                    last_next  = winner;
                    abort_next = 1'b0;
                    op_i_next  = chan_i[winner];
                    op_q_next  = chan_q[winner];
                end
            end
            ST_ISSUE: begin
                state_next = ST_WAIT;
                count_next = '0;
            end
            ST_WAIT: begin
                count_next = count_reg + 16'd1;
                // A completion on the timeout cycle takes priority over the abort.
                if (Cordic_Ready) begin
                    state_next  = ST_DONE;
                    abort_next  = 1'b0;
                    res_pm_next = PM;
                    res_am_next = AM;
                end else if (timeout_hit) begin
                    state_next  = ST_DONE;
                    abort_next  = 1'b1;
                    res_pm_next = '0;
                    res_am_next = '0;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= 1'b0;
            last_reg   <= 1'b1;
            abort_reg  <= 1'b0;
            count_reg  <= '0;
            op_i_reg   <= '0;
            op_q_reg   <= '0;
            res_pm_reg <= '0;
            res_am_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            last_reg   <= last_next;
            abort_reg  <= abort_next;
            count_reg  <= count_next;
            op_i_reg   <= op_i_next;
            op_q_reg   <= op_q_next;
            res_pm_reg <= res_pm_next;
            res_am_reg <= res_am_next;
        end
    end

    // Per-channel strobes are decoded from state and owner, so reset clears them at once.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            assign grant_vec[gi] = (state_reg == ST_ISSUE) && (owner_reg == 1'(gi));
            assign done_vec[gi]  = (state_reg == ST_DONE) && !abort_reg && (owner_reg == 1'(gi));
            assign err_vec[gi]   = (state_reg == ST_DONE) && abort_reg && (owner_reg == 1'(gi));
        end
    endgenerate

    assign Grant0        = grant_vec[0];
    assign Grant1        = grant_vec[1];
    assign Done0         = done_vec[0];
    assign Done1         = done_vec[1];
    assign Err0          = err_vec[0];
    assign Err1          = err_vec[1];
    assign Cordic_Enable = (state_reg == ST_ISSUE);
    assign Busy          = (state_reg != ST_IDLE);
    assign I             = op_i_reg;
    assign Q             = op_q_reg;
    assign Res_PM        = res_pm_reg;
    assign Res_AM        = res_am_reg;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: per-step assertions plus a scoreboard
// of expected Done/Err events checked by a completion monitor.
module tb_cordic_arbiter;

    localparam int W  = 13;
    localparam int TO = 8;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Req0, Req1;
    logic [W-1:0] I0, Q0, I1, Q1;
    logic         Grant0, Grant1, Done0, Done1, Err0, Err1;
    logic [W-1:0] Res_PM, Res_AM;
    logic         Busy, Cordic_Enable;
    logic [W-1:0] I, Q;
    logic         Cordic_Ready;
    logic [W-1:0] PM, AM;

    typedef struct {
        int           ch;
        bit           err;
        logic [W-1:0] pm;
        logic [W-1:0] am;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    cordic_arbiter #(.TIMEOUT(TO), .W(W)) dut (
        .CLK(CLK), .RESET(RESET),
        .Req0(Req0), .Req1(Req1),
        .I0(I0), .Q0(Q0), .I1(I1), .Q1(Q1),
        .Grant0(Grant0), .Grant1(Grant1),
        .Done0(Done0), .Done1(Done1),
        .Err0(Err0), .Err1(Err1),
        .Res_PM(Res_PM), .Res_AM(Res_AM),
        .Busy(Busy), .Cordic_Enable(Cordic_Enable),
        .I(I), .Q(Q),
        .Cordic_Ready(Cordic_Ready), .PM(PM), .AM(AM)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Completion monitor: every Done/Err pulse must match the oldest expectation.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && (Done0 || Done1 || Err0 || Err1)) begin
            sb_item_t it;
            chk("done_err_exclusive", 32'((Done0 | Done1) & (Err0 | Err1)), 32'd0);
            chk("sb_expected_event", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                chk("sb_done0", 32'(Done0), 32'(!it.err && it.ch == 0));
                chk("sb_done1", 32'(Done1), 32'(!it.err && it.ch == 1));
                chk("sb_err0", 32'(Err0), 32'(it.err && it.ch == 0));
                chk("sb_err1", 32'(Err1), 32'(it.err && it.ch == 1));
                chk("sb_res_pm", 32'(Res_PM), 32'(it.pm));
                chk("sb_res_am", 32'(Res_AM), 32'(it.am));
                $display("txn ch=%0d err=%0b res_pm=%h res_am=%h", it.ch, it.err, Res_PM, Res_AM);
            end
        end
    end

    task automatic set_ops(input logic [W-1:0] i0, q0, i1, q1);
        I0 = i0; Q0 = q0; I1 = i1; Q1 = q1;
    endtask

    // One full transaction from an IDLE cycle back to the following IDLE cycle.
    // rdy_at is the 0-based WAIT cycle on which Ready rises; >= TO means never.
    task automatic do_txn(input logic r0, input logic r1, input int exp_ch, input int rdy_at,
                          input logic [W-1:0] exp_i, input logic [W-1:0] exp_q,
                          input logic [W-1:0] pm, input logic [W-1:0] am);
        sb_item_t it;
        bit abort;
        int n;
        abort = (rdy_at >= TO);
        Req0 = r0;
        Req1 = r1;
        tick();
        chk("grant0", 32'(Grant0), 32'(exp_ch == 0));
        chk("grant1", 32'(Grant1), 32'(exp_ch == 1));
        chk("enable_issue", 32'(Cordic_Enable), 32'd1);
        chk("busy_issue", 32'(Busy), 32'd1);
        chk("op_i", 32'(I), 32'(exp_i));
        chk("op_q", 32'(Q), 32'(exp_q));
        it.ch  = exp_ch;
        it.err = abort;
        it.pm  = abort ? '0 : pm;
        it.am  = abort ? '0 : am;
        sb.push_back(it);
        set_ops(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1FFF);
        tick();
        chk("enable_wait", 32'(Cordic_Enable), 32'd0);
        n = abort ? TO - 1 : rdy_at;
        for (int k = 0; k < n; k++) begin
            tick();
            chk("no_early_done", 32'(Done0 | Done1 | Err0 | Err1), 32'd0);
        end
        if (!abort) begin
            Cordic_Ready = 1'b1;
            PM = pm;
            AM = am;
        end
        tick();
        Cordic_Ready = 1'b0;
        PM = ~pm;
        AM = ~am;
        chk("done0", 32'(Done0), 32'(!abort && exp_ch == 0));
        chk("done1", 32'(Done1), 32'(!abort && exp_ch == 1));
        chk("err0", 32'(Err0), 32'(abort && exp_ch == 0));
        chk("err1", 32'(Err1), 32'(abort && exp_ch == 1));
        chk("busy_done", 32'(Busy), 32'd1);
        chk("op_i_hold", 32'(I), 32'(exp_i));
        tick();
        chk("busy_idle", 32'(Busy), 32'd0);
        chk("grant_idle", 32'(Grant0 | Grant1), 32'd0);
        chk("strobe_idle", 32'(Done0 | Done1 | Err0 | Err1), 32'd0);
        chk("res_pm_hold", 32'(Res_PM), 32'(it.pm));
        chk("res_am_hold", 32'(Res_AM), 32'(it.am));
        Req0 = 1'b0;
        Req1 = 1'b0;
    endtask

    initial begin
        RESET = 1'b0;
        Req0 = 1'b0; Req1 = 1'b0;
        set_ops('0, '0, '0, '0);
        Cordic_Ready = 1'b0;
        PM = '0; AM = '0;
        repeat (2) tick();
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_grant", 32'({Grant1, Grant0}), 32'd0);
        chk("rst_done_err", 32'({Done1, Done0, Err1, Err0}), 32'd0);
        chk("rst_enable", 32'(Cordic_Enable), 32'd0);
        chk("rst_iq", 32'({I, Q}), 32'd0);
        chk("rst_res", 32'({Res_PM, Res_AM}), 32'd0);
        RESET = 1'b1;

        // Round-robin with both requests held: 0, 1, 0, 1.
        set_ops(13'h0011, 13'h0012, 13'h0021, 13'h0022);
        do_txn(1, 1, 0, 0, 13'h0011, 13'h0012, 13'h0101, 13'h0102);
        set_ops(13'h0031, 13'h0032, 13'h0041, 13'h0042);
        do_txn(1, 1, 1, 2, 13'h0041, 13'h0042, 13'h0201, 13'h0202);
        set_ops(13'h0051, 13'h0052, 13'h0061, 13'h0062);
        do_txn(1, 1, 0, 1, 13'h0051, 13'h0052, 13'h0301, 13'h0302);
        set_ops(13'h0071, 13'h0072, 13'h0081, 13'h0082);
        do_txn(1, 1, 1, 0, 13'h0081, 13'h0082, 13'h0401, 13'h0402);

        // Single request on channel 0 with operand isolation after the grant.
        set_ops(13'h0100, 13'h0080, 13'h0AAA, 13'h0555);
        do_txn(1, 0, 0, 0, 13'h0100, 13'h0080, 13'h0123, 13'h0456);

        // Watchdog abort on channel 1.
        set_ops(13'h0003, 13'h0004, 13'h0777, 13'h0888);
        do_txn(0, 1, 1, 100, 13'h0777, 13'h0888, 13'h0999, 13'h0AAA);

        // Ready arriving on the timeout cycle wins.
        set_ops(13'h0005, 13'h0006, 13'h0E01, 13'h0E02);
        do_txn(0, 1, 1, TO - 1, 13'h0E01, 13'h0E02, 13'h1ABC, 13'h0DEF);

        // Reset in WAIT drops the transaction.
        set_ops(13'h0C0C, 13'h0D0D, 13'h0E0E, 13'h0F0F);
        Req0 = 1'b1; Req1 = 1'b1;
        tick();
        chk("pre_rst_grant0", 32'(Grant0), 32'd1);
        Req0 = 1'b0; Req1 = 1'b0;
        repeat (2) tick();
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        RESET = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(Busy), 32'd0);
        chk("mid_rst_outs", 32'({Grant1, Grant0, Done1, Done0, Err1, Err0, Cordic_Enable}), 32'd0);
        chk("mid_rst_iq", 32'({I, Q}), 32'd0);
        chk("mid_rst_res", 32'({Res_PM, Res_AM}), 32'd0);
        repeat (2) tick();
        RESET = 1'b1;
        Cordic_Ready = 1'b1;
        PM = 13'h1111; AM = 13'h0222;
        tick();
        Cordic_Ready = 1'b0;
        chk("late_ready_busy", 32'(Busy), 32'd0);
        tick();
        chk("late_ready_strobes", 32'({Done1, Done0, Err1, Err0}), 32'd0);
        chk("late_ready_res", 32'({Res_PM, Res_AM}), 32'd0);

        // First tie after reset goes to channel 0 again.
        set_ops(13'h0123, 13'h0321, 13'h0456, 13'h0654);
        do_txn(1, 1, 0, 3, 13'h0123, 13'h0321, 13'h0ACE, 13'h0BDF);

        repeat (2) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
